// File: rtl/sram_pkg.sv
// Shared SRAM bus widths and the device-model state encoding.
// The SRAM controller imports the same width constants.
package sram_pkg;
   localparam int SRAM_DW = 16;
   localparam int SRAM_AW = 18;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } sram_state_e;
endpackage

// File: rtl/sram_lane_array.sv
// Two-lane byte-writable synchronous RAM: one write port with per-lane enables,
// one registered read port with a synchronous clear of the read register.
module sram_lane_array
   import sram_pkg::*;
#(
   parameter int AW = 10
) (
   input  logic               clk,
   input  logic               we_lo_i,
   input  logic               we_hi_i,
   input  logic [AW-1:0]      waddr_i,
   input  logic [SRAM_DW-1:0] wdata_i,
   input  logic               re_i,
   input  logic               rd_clr_i,
   input  logic [AW-1:0]      raddr_i,
   output logic [SRAM_DW-1:0] rdata_o
);
   localparam int BW = SRAM_DW / 2;

   logic [BW-1:0]      lo_q [2**AW];
   logic [BW-1:0]      hi_q [2**AW];
   logic [SRAM_DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_lo_i) lo_q[waddr_i] <= wdata_i[BW-1:0];
      if (we_hi_i) hi_q[waddr_i] <= wdata_i[SRAM_DW-1:BW];
   end

   // Clear has priority so reset and out-of-range fetches both return zero.
   always_ff @(posedge clk) begin
      if (rd_clr_i)  rdata_q <= '0;
      else if (re_i) rdata_q <= {hi_q[raddr_i], lo_q[raddr_i]};
   end

   assign rdata_o = rdata_q;
endmodule

// File: rtl/sram_device_model.sv
// Synthesizable responder for the 16-bit asynchronous SRAM bus: backs a reduced-depth
// array, zero-fills it after reset, and flags out-of-range accesses.
module sram_device_model
   import sram_pkg::*;
#(
   parameter int DEPTH_LOG2     = 10,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SRAM_AW-1:0] SRAM_ADDR,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ,
   input  logic               SRAM_WE_N,
   input  logic               SRAM_OE_N,
   input  logic               SRAM_CE_N,
   input  logic               SRAM_UB_N,
   input  logic               SRAM_LB_N,
   output logic               init_done,
   output logic               oor_err
);
   sram_state_e            state_q, state_d;
   logic [DEPTH_LOG2-1:0]  clr_ptr_q, clr_ptr_d;
   logic                   rd_valid_q, rd_valid_d;
   logic                   init_done_q, init_done_d;
   logic                   oor_err_q, oor_err_d;

   logic [SRAM_AW-1:0]     addr_hi;
   logic                   in_range, fetch, bus_wr;
   logic                   we_lo, we_hi, rd_clr, drv_lo, drv_hi;
   logic [DEPTH_LOG2-1:0]  waddr;
   logic [SRAM_DW-1:0]     wdata, rd_data;

   // Upper address bits only feed the range check; the array never aliases.
   assign addr_hi  = SRAM_ADDR >> DEPTH_LOG2;
   assign in_range = (addr_hi == '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= INIT;
         clr_ptr_q   <= '0;
         rd_valid_q  <= 1'b0;
         init_done_q <= 1'b0;
         oor_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         clr_ptr_q   <= clr_ptr_d;
         rd_valid_q  <= rd_valid_d;
         init_done_q <= init_done_d;
         oor_err_q   <= oor_err_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_ptr_d = clr_ptr_q;
      if (state_q == INIT) begin
         clr_ptr_d = clr_ptr_q + 1'b1;
         if (!CLEAR_ON_RESET || (clr_ptr_q == {DEPTH_LOG2{1'b1}})) state_d = RUN;
      end
   end

   always_comb begin
      fetch       = rst && (state_q == RUN) && !SRAM_CE_N && SRAM_WE_N;
      bus_wr      = rst && (state_q == RUN) && !SRAM_CE_N && !SRAM_WE_N && in_range;
      rd_valid_d  = fetch;
      init_done_d = (state_d == RUN);
      oor_err_d   = oor_err_q || ((state_q == RUN) && !SRAM_CE_N && !in_range);
      rd_clr      = !rst || (fetch && !in_range);
      we_lo       = bus_wr && !SRAM_LB_N;
      we_hi       = bus_wr && !SRAM_UB_N;
      waddr       = SRAM_ADDR[DEPTH_LOG2-1:0];
      wdata       = SRAM_DQ;
      // The clear sweep takes over the write port for the whole INIT phase.
      if (state_q == INIT) begin
         we_lo = CLEAR_ON_RESET;
         we_hi = CLEAR_ON_RESET;
         waddr = clr_ptr_q;
         wdata = '0;
      end
   end

   sram_lane_array #(.AW(DEPTH_LOG2)) u_array (
      .clk      (clk),
      .we_lo_i  (we_lo),
      .we_hi_i  (we_hi),
      .waddr_i  (waddr),
      .wdata_i  (wdata),
      .re_i     (fetch),
      .rd_clr_i (rd_clr),
      .raddr_i  (SRAM_ADDR[DEPTH_LOG2-1:0]),
      .rdata_o  (rd_data)
   );

   // Drive follows the live strobes so a falling WE_N releases the bus at once.
   assign drv_lo = rd_valid_q && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_LB_N;
   assign drv_hi = rd_valid_q && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_UB_N;

   assign SRAM_DQ[7:0]  = drv_lo ? rd_data[7:0]  : 8'hzz;
   assign SRAM_DQ[15:8] = drv_hi ? rd_data[15:8] : 8'hzz;

   assign init_done = init_done_q;
   assign oor_err   = oor_err_q;
endmodule

// File: doc/sram_device_model.md
Name: sram_device_model

Overview:
- Synthesizable responder for the 16-bit asynchronous SRAM bus (18-bit word address, byte-lane enables, active-low strobes).
- Sits on the far side of the SRAM controller. It stands in for the external SRAM chip in simulation and in on-chip test builds that have no external part.
- Backs a reduced-depth word array and clears it after reset.
- Reports initialisation completion and a sticky out-of-range access flag.

Parameters:
- DEPTH_LOG2, 10, number of implemented 16-bit words = 2^DEPTH_LOG2 (max 18).
- CLEAR_ON_RESET, 1, when 1 the array is zero-filled after reset; when 0 the array is left untouched.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a rising edge resets).
- SRAM_ADDR  in  18  word address.
- SRAM_DQ  inout  16  bidirectional data; driven by this block only during reads.
- SRAM_WE_N  in  1  write strobe, active-low.
- SRAM_OE_N  in  1  output enable, active-low.
- SRAM_CE_N  in  1  chip enable, active-low.
- SRAM_UB_N  in  1  upper byte lane [15:8] enable, active-low.
- SRAM_LB_N  in  1  lower byte lane [7:0] enable, active-low.
- init_done  out  1  high once the array is usable.
- oor_err  out  1  sticky: an access hit an address >= 2^DEPTH_LOG2.

Behaviour:
- Reset (rst==0 at edge):
  - state<=INIT, clr_ptr<=0, rd_data<=16'h0000, rd_valid<=0, init_done<=0, oor_err<=0.
  - SRAM_DQ is hi-Z.
  - Reset asserted mid-clear restarts the clear from word 0.
- INIT state:
  - CLEAR_ON_RESET=1: each cycle writes 16'h0000 to word clr_ptr, then clr_ptr++.
  - After word 2^DEPTH_LOG2-1 is written, next state is RUN and init_done<=1, i.e. 2^DEPTH_LOG2 cycles after reset release.
  - CLEAR_ON_RESET=0: RUN and init_done=1 one cycle after reset release.
  - While in INIT, all bus activity is ignored: no writes, no reads, DQ hi-Z, oor_err unchanged.
- RUN state, write (CE_N=0, WE_N=0 at edge):
  - LB_N==0: mem[a][7:0]<=DQ[7:0].
  - UB_N==0: mem[a][15:8]<=DQ[15:8].
  - Both lanes disabled: no change.
  - WE_N=0 overrides OE_N. No drive in a write cycle even if OE_N=0.
- RUN state, read fetch (CE_N=0, WE_N=1 at edge):
  - rd_data<=mem[a] and rd_valid<=1.
  - Otherwise rd_valid<=0.
  - Latency: data appears on DQ in the cycle after the address was presented, i.e. registered read, one cycle.
  - An address held for N cycles yields valid data from cycle 2 onward.
- DQ drive (combinational on current strobes):
  - DQ[7:0]=rd_data[7:0] when rd_valid & ~CE_N & ~OE_N & WE_N & ~LB_N; else hi-Z.
  - Same rule for [15:8] with UB_N.
  - WE_N falling kills the drive in the same cycle; there is no bus contention.
- Read-after-write to the same address in consecutive cycles returns the newly written data.
- Out of range (a >= 2^DEPTH_LOG2, CE_N=0, in RUN):
  - Write is dropped.
  - Read returns 16'h0000.
  - oor_err<=1 and stays high until reset.
- Address width: only a[DEPTH_LOG2-1:0] indexes the array. Upper bits are used only for the range check; there is no aliasing.
- CE_N=1: no access, rd_valid<=0, DQ hi-Z, regardless of other strobes.

Decomposition:
- Shared package sram_pkg: SRAM_DW=16, SRAM_AW=18, and state encodings INIT=1'b0, RUN=1'b1. The SRAM controller imports the same width constants.
- One sub-module: sram_lane_array, a two-lane byte-writable synchronous RAM.
  - One write port with per-lane enables; one registered read port.
  - Used both for the clear sweep and for bus writes, muxed by state.

Test Plan:
- Reset release with DEPTH_LOG2=4, CLEAR_ON_RESET=1: init_done rises exactly 16 cycles after rst goes high. A subsequent read of address 5 returns 16'h0000.
- Full-word write/read: write 16'hBEEF to address 3 (UB_N=LB_N=0). Next cycle present address 3 with OE_N=0. DQ==16'hBEEF one cycle later; DQ hi-Z during the write cycle.
- Byte lanes: write 16'h1234 to address 7, then write 16'hAB00 with LB_N=1. Read returns 16'hAB34. A read with UB_N=1 drives only DQ[7:0]=8'h34, and DQ[15:8] is hi-Z.
- Controller sequence: write 32'hCAFE_F00D to words 8/9 (low then high), then read 8 and 9 with one-cycle address-before-sample timing. Returns 16'hF00D and 16'hCAFE.
- Out of range with DEPTH_LOG2=4: write 16'h5555 to address 18'h10. oor_err rises and stays high; address 0 is unchanged at 16'h0000; a read of 18'h10 returns 16'h0000.
- Reset mid-clear: assert rst after 6 INIT cycles, release. init_done rises exactly 16 cycles after the second release. Bus writes issued during INIT leave memory at 16'h0000.
